// File: rtl/imem_fetch_port.sv
// imem_fetch_port: word-addressed instruction memory with one fetch in flight; define IMEM_LINE_BUF_EN for a 4-word line buffer.
// Latency: LATENCY cycles from acceptance to the resp_valid pulse (1 cycle for line-buffer hits).
// Backpressure: req_ready is low while a fetch is outstanding or flush is high; responses cannot be stalled.
module imem_fetch_port #(
   parameter int    DEPTH     = 1024,
   parameter int    LATENCY   = 3,
   parameter string INIT_FILE = "program.hex"
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_instr,
   output logic        resp_err
);

   localparam int AW = (DEPTH > 4) ? $clog2(DEPTH) : 2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {IDLE, BUSY} state_t;

   logic [31:0] memory [DEPTH];

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] addr_q, addr_nx;
   logic        resp_valid_nx, resp_err_nx;
   logic [31:0] resp_instr_nx;
   logic        accept, do_resp;
   logic [31:0] lk_addr, lk_instr;
   logic        lk_err;

   assign req_ready = (state == IDLE) && !flush && rst_n;
   assign accept    = req_valid && req_ready;

   // Single lookup port: the live request while idle, the latched address while busy.
   assign lk_addr  = (state == IDLE) ? req_addr : addr_q;
   assign lk_err   = (lk_addr[1:0] != 2'b00) || ({2'b00, lk_addr[31:2]} >= 32'(DEPTH));
   assign lk_instr = lk_err ? NOP : memory[lk_addr[AW+1:2]];

`ifdef IMEM_LINE_BUF_EN
   logic        lb_valid, lb_valid_nx;
   logic [27:0] lb_tag, lb_tag_nx;
   logic [31:0] lb_data [4];
   logic [31:0] lb_data_nx [4];
   logic        lb_hit;

   assign lb_hit = lb_valid && !lk_err && (lb_tag == lk_addr[31:4]);
`endif

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      addr_nx       = addr_q;
      resp_valid_nx = 1'b0;
      resp_instr_nx = resp_instr;
      resp_err_nx   = resp_err;
      do_resp       = 1'b0;
`ifdef IMEM_LINE_BUF_EN
      lb_valid_nx = lb_valid;
      lb_tag_nx   = lb_tag;
      lb_data_nx  = lb_data;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef IMEM_LINE_BUF_EN
               if (lb_hit) begin
                  resp_valid_nx = 1'b1;
                  resp_instr_nx = lb_data[lk_addr[3:2]];
                  resp_err_nx   = 1'b0;
               end else
`endif
               if (LATENCY == 1) begin
                  do_resp = 1'b1;
               end else begin
                  state_nx = BUSY;
                  cnt_nx   = 4'(LATENCY - 1);
                  addr_nx  = req_addr;
               end
            end
         end
         BUSY: begin
            if (flush) begin
               state_nx = IDLE;
               cnt_nx   = 4'd0;
            end else if (cnt == 4'd1) begin
               do_resp  = 1'b1;
               state_nx = IDLE;
               cnt_nx   = 4'd0;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (do_resp) begin
         resp_valid_nx = 1'b1;
         resp_instr_nx = lk_instr;
         resp_err_nx   = lk_err;
`ifdef IMEM_LINE_BUF_EN
         if (!lk_err) begin
            lb_valid_nx = 1'b1;
            lb_tag_nx   = lk_addr[31:4];
            for (int w = 0; w < 4; w++) lb_data_nx[w] = memory[{lk_addr[AW+1:4], 2'(w)}];
         end
`endif
      end
`ifdef IMEM_LINE_BUF_EN
      if (flush) lb_valid_nx = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         addr_q     <= 32'h0;
         resp_valid <= 1'b0;
         resp_instr <= 32'h0;
         resp_err   <= 1'b0;
`ifdef IMEM_LINE_BUF_EN
         lb_valid <= 1'b0;
         lb_tag   <= 28'h0;
         for (int w = 0; w < 4; w++) lb_data[w] <= 32'h0;
`endif
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         addr_q     <= addr_nx;
         resp_valid <= resp_valid_nx;
         resp_instr <= resp_instr_nx;
         resp_err   <= resp_err_nx;
`ifdef IMEM_LINE_BUF_EN
         lb_valid <= lb_valid_nx;
         lb_tag   <= lb_tag_nx;
         for (int w = 0; w < 4; w++) lb_data[w] <= lb_data_nx[w];
`endif
      end
   end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: transaction-level model (queue of due responses) checked every cycle,
// plus literal expectations for the directed sequences.
module tb_imem_fetch_port;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 3;
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_LINE_BUF_EN
   localparam bit LB      = 1'b1;
   localparam int HIT_LAT = 1;
`else
   localparam bit LB      = 1'b0;
   localparam int HIT_LAT = LATENCY;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic        flush = 1'b0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_instr;

   imem_fetch_port #(.DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_FILE("")) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid),
      .resp_instr(resp_instr), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        err;
      bit          fill;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mem_model [DEPTH];
   bit          line_vld = 1'b0;
   logic [27:0] line_tag = 28'h0;
   int          n_chk = 0, n_pass = 0, n_resp = 0;
   int          log_cyc [64];
   logic [31:0] log_instr [64];
   logic        log_err [64];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
   endtask

   // Model: a fetch accepted at the end of cycle c responds in cycle c+LATENCY (c+1 on a line hit).
   always @(negedge clk) begin : mon
      bit   exp_vld, exp_rdy, hit;
      ent_t e;
      if (!rst_n) begin
         chk("reset resp_valid", 32'(resp_valid), 32'h0);
         chk("reset resp_instr", resp_instr, 32'h0);
         chk("reset resp_err", 32'(resp_err), 32'h0);
         chk("reset req_ready", 32'(req_ready), 32'h0);
         q.delete();
         line_vld = 1'b0;
      end else begin
         exp_vld = (q.size() > 0) && (q[0].due == cyc);
         chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
         if (exp_vld) begin
            chk("resp_instr", resp_instr, q[0].instr);
            chk("resp_err", 32'(resp_err), 32'(q[0].err));
            if (q[0].fill) begin
               line_vld = 1'b1;
               line_tag = q[0].addr[31:4];
            end
            void'(q.pop_front());
         end
         if (resp_valid) begin
            if (n_resp < 64) begin
               log_cyc[n_resp]   = cyc;
               log_instr[n_resp] = resp_instr;
               log_err[n_resp]   = resp_err;
            end
            n_resp++;
         end
         exp_rdy = (q.size() == 0) && !flush;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         if (flush) begin
            q.delete();
            line_vld = 1'b0;
         end else if (req_valid && exp_rdy) begin
            e.addr  = req_addr;
            e.err   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
            e.instr = e.err ? NOP : mem_model[req_addr[11:2]];
            hit     = LB && !e.err && line_vld && (line_tag == req_addr[31:4]);
            e.due   = cyc + (hit ? 1 : LATENCY);
            e.fill  = LB && !e.err && !hit;
            q.push_back(e);
         end
      end
   end

   task automatic fetch(input logic [31:0] a, output int acc);
      req_valid = 1'b1;
      req_addr  = a;
      acc       = -1;
      for (int k = 0; k < 20 && acc < 0; k++) begin
         @(negedge clk);
         if (req_ready) acc = cyc;
      end
      if (acc < 0) begin
         n_chk++;
         $display("FAIL accept_timeout addr %h: req_ready stayed 0, needed 1", a);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_flush();
      req_valid = 1'b0;
      flush     = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic chk_resp(input string nm, input int idx, input int acc, input int lat,
                           input logic [31:0] instr, input logic err);
      if (idx >= n_resp) begin
         n_chk++;
         $display("FAIL %s: response %0d never seen, only %0d responses", nm, idx, n_resp);
      end else begin
         chk({nm, " latency"}, 32'(log_cyc[idx] - acc), 32'(lat));
         chk({nm, " instr"}, log_instr[idx], instr);
         chk({nm, " err"}, 32'(log_err[idx]), 32'(err));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench still running at %0t, needed to finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, a3, a4, base;
      for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0203);
      mem_model[0] = 32'h0010_0093;
      mem_model[1] = 32'h0020_8113;
      mem_model[2] = 32'h0031_0193;
      mem_model[3] = 32'h0041_8213;
      for (int i = 0; i < DEPTH; i++) dut.memory[i] = mem_model[i];

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready after reset", 32'(req_ready), 32'h1);
      @(posedge clk); #1;

      pulse_flush();
      base = n_resp;
      fetch(32'h0, a0);
      idle(5);
      chk("single fetch count", 32'(n_resp - base), 32'h1);
      chk_resp("single", base, a0, 3, 32'h0010_0093, 1'b0);

      pulse_flush();
      base = n_resp;
      fetch(32'h0, a0);
      fetch(32'h4, a1);
      fetch(32'h8, a2);
      idle(6);
      chk("b2b count", 32'(n_resp - base), 32'h3);
      chk_resp("b2b0", base, a0, 3, 32'h0010_0093, 1'b0);
      chk_resp("b2b1", base + 1, a1, HIT_LAT, 32'h0020_8113, 1'b0);
      chk_resp("b2b2", base + 2, a2, HIT_LAT, 32'h0031_0193, 1'b0);

      pulse_flush();
      base = n_resp;
      fetch(32'h2, a0);
      fetch(32'(4 * DEPTH), a1);
      idle(6);
      chk_resp("misaligned", base, a0, 3, NOP, 1'b1);
      chk_resp("out of range", base + 1, a1, 3, NOP, 1'b1);

      pulse_flush();
      base = n_resp;
      fetch(32'h8, a0);
      pulse_flush();
      @(negedge clk);
      chk("ready after flush", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      idle(4);
      chk("flushed fetch silent", 32'(n_resp - base), 32'h0);
      fetch(32'hC, a1);
      idle(5);
      chk_resp("after flush", base, a1, 3, 32'h0041_8213, 1'b0);

`ifdef IMEM_LINE_BUF_EN
      pulse_flush();
      base = n_resp;
      fetch(32'h0, a0);
      fetch(32'h4, a1);
      fetch(32'h8, a2);
      fetch(32'hC, a3);
      fetch(32'h10, a4);
      idle(6);
      chk_resp("line miss0", base, a0, 3, 32'h0010_0093, 1'b0);
      chk_resp("line hit4", base + 1, a1, 1, 32'h0020_8113, 1'b0);
      chk_resp("line hit8", base + 2, a2, 1, 32'h0031_0193, 1'b0);
      chk_resp("line hitC", base + 3, a3, 1, 32'h0041_8213, 1'b0);
      chk_resp("line miss10", base + 4, a4, 3, mem_model[4], 1'b0);
      pulse_flush();
      fetch(32'h10, a0);
      idle(5);
      chk_resp("line flushed", base + 5, a0, 3, mem_model[4], 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
